// File: rtl/pb_cmd_pkg.sv
// Shared types for the peripheral-bus command scheduler: opcodes, response status,
// scheduler states, substate bit positions and the opcode-to-activation decode.
package pb_cmd_pkg;

  localparam int unsigned NUM_SUB = 5;

  typedef enum logic [2:0] {
    OP_WRITE4 = 3'd0,
    OP_READ4  = 3'd1,
    OP_ADC4   = 3'd2,
    OP_ADC1   = 3'd3,
    OP_TEST   = 3'd4
  } opcode_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_TIMEOUT = 2'd1,
    ST_ILLEGAL = 2'd2
  } rsp_status_e;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_RELEASE   = 3'd3,
    S_RESPOND   = 3'd4
  } sched_state_e;

  // Bit positions inside substate_active / substate_complete
  typedef enum int unsigned {
    BIT_WRITE4 = 0,
    BIT_READ4  = 1,
    BIT_ADC4   = 2,
    BIT_ADC1   = 3,
    BIT_TEST   = 4
  } sub_bit_e;

  // Illegal opcodes decode to no activation at all
  function automatic logic [NUM_SUB-1:0] op_onehot(input logic [2:0] op);
    op_onehot = '0;
    if (op <= OP_TEST) op_onehot = NUM_SUB'(NUM_SUB'(1) << op);
  endfunction

endpackage

// File: rtl/pb_handshake_timer.sv
// Saturating per-phase timer; expiry flags the last cycle a handshake phase may last,
// so a phase spans exactly TIMEOUT_CYCLES cycles before it is abandoned.
module pb_handshake_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 27000
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired_c
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != CW'(TIMEOUT_CYCLES))) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_expired_c = (r_count >= CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/pb_command_scheduler.sv
// Single-owner scheduler for the peripheral-bus substate machines: accepts a command,
// runs one 4-phase active/complete handshake with timeouts, then offers a response frame.
module pb_command_scheduler
  import pb_cmd_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 27000000,
  parameter int unsigned TIMEOUT_CYCLES  = CLOCK_FREQUENCY / 1000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [2:0]          cmd_opcode,
  input  logic [1:0]          cmd_type,
  input  logic [31:0]         cmd_params,
  output logic [3:0][7:0]     command_param_data,
  output logic [1:0]          CommandType,
  output logic [NUM_SUB-1:0]  substate_active,
  input  logic [NUM_SUB-1:0]  substate_complete,
  input  logic [3:0][7:0]     ResponseBytes,
  input  logic [3:0]          ResponseByteCount,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [1:0]          rsp_status,
  output logic [3:0]          rsp_count,
  output logic [31:0]         rsp_bytes,
  output logic                busy
);

  sched_state_e       r_state;
  logic [3:0][7:0]    r_params;
  logic [1:0]         r_type;
  logic [NUM_SUB-1:0] r_sel;
  logic [NUM_SUB-1:0] r_active;
  logic               r_busy;
  logic               r_rsp_valid;
  rsp_status_e        r_status;
  logic [3:0]         r_count;
  logic [31:0]        r_bytes;

  logic               w_done;
  logic               w_expired;
  logic               w_timer_clear;
  logic               w_timer_en;
  logic [3:0]         w_count_clamped;

  // Only the selected sequence's completion bit is ever observed
  assign w_done          = |(substate_complete & r_sel);
  assign w_count_clamped = (ResponseByteCount > 4'd4) ? 4'd4 : ResponseByteCount;
  assign w_timer_en      = (r_state == S_WAIT_DONE) || (r_state == S_RELEASE);
  assign w_timer_clear   = (r_state == S_START) ||
                           ((r_state == S_WAIT_DONE) && (w_done || w_expired));

  pb_handshake_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clock       (clock),
    .reset       (reset),
    .i_clear     (w_timer_clear),
    .i_enable    (w_timer_en),
    .o_expired_c (w_expired)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_params    <= '0;
      r_type      <= '0;
      r_sel       <= '0;
      r_active    <= '0;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_status    <= ST_OK;
      r_count     <= '0;
      r_bytes     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_params <= cmd_params;
            r_type   <= cmd_type;
            r_sel    <= op_onehot(cmd_opcode);
            r_busy   <= 1'b1;
            if (cmd_opcode > OP_TEST) begin
              r_status    <= ST_ILLEGAL;
              r_count     <= '0;
              r_bytes     <= '0;
              r_rsp_valid <= 1'b1;
              r_state     <= S_RESPOND;
            end else begin
              r_state <= S_START;
            end
          end
        end
        S_START: begin
          r_active <= r_sel;
          r_state  <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (w_done) begin
            r_bytes  <= ResponseBytes;
            r_count  <= w_count_clamped;
            r_status <= ST_OK;
            r_active <= '0;
            r_state  <= S_RELEASE;
          end else if (w_expired) begin
            r_bytes  <= '0;
            r_count  <= '0;
            r_status <= ST_TIMEOUT;
            r_active <= '0;
            r_state  <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          // Wait for the sequence to drop complete before anyone else may own the bus
          if (!w_done) begin
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESPOND;
          end else if (w_expired) begin
            r_bytes     <= '0;
            r_count     <= '0;
            r_status    <= ST_TIMEOUT;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESPOND;
          end
        end
        S_RESPOND: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready          = (r_state == S_IDLE);
  assign command_param_data = r_params;
  assign CommandType        = r_type;
  assign substate_active    = r_active;
  assign rsp_valid          = r_rsp_valid;
  assign rsp_status         = r_status;
  assign rsp_count          = r_count;
  assign rsp_bytes          = r_bytes;
  assign busy               = r_busy;

endmodule

// File: tb/tb_pb_command_scheduler.sv
// Self-checking bench for pb_command_scheduler: deadline-based reference model compared
// every cycle, directed handshake scenarios plus randomized command traffic.
module tb_pb_command_scheduler;

  localparam int TO = 64;
  localparam int P_IDLE = 0, P_START = 1, P_WAIT = 2, P_REL = 3, P_RSP = 4;

  logic            clock;
  logic            reset;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [2:0]      cmd_opcode;
  logic [1:0]      cmd_type;
  logic [31:0]     cmd_params;
  logic [3:0][7:0] command_param_data;
  logic [1:0]      CommandType;
  logic [4:0]      substate_active;
  logic [4:0]      substate_complete;
  logic [3:0][7:0] ResponseBytes;
  logic [3:0]      ResponseByteCount;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_status;
  logic [3:0]      rsp_count;
  logic [31:0]     rsp_bytes;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;
  int act_cycles = 0;
  logic [4:0] act_seen = '0;

  pb_command_scheduler #(.TIMEOUT_CYCLES(TO)) dut (
    .clock              (clock),
    .reset              (reset),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_opcode         (cmd_opcode),
    .cmd_type           (cmd_type),
    .cmd_params         (cmd_params),
    .command_param_data (command_param_data),
    .CommandType        (CommandType),
    .substate_active    (substate_active),
    .substate_complete  (substate_complete),
    .ResponseBytes      (ResponseBytes),
    .ResponseByteCount  (ResponseByteCount),
    .rsp_valid          (rsp_valid),
    .rsp_ready          (rsp_ready),
    .rsp_status         (rsp_status),
    .rsp_count          (rsp_count),
    .rsp_bytes          (rsp_bytes),
    .busy               (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each phase ends at an absolute deadline cycle rather than a counter
  int         cyc = 0;
  int         m_phase = P_IDLE;
  int         m_deadline = 0;
  logic [2:0] m_bit = '0;
  logic [4:0] m_active = '0;
  logic       m_busy = 1'b0;
  logic       m_rsp_valid = 1'b0;
  logic [1:0] m_status = '0;
  logic [1:0] m_type = '0;
  logic [3:0] m_count = '0;
  logic [31:0] m_bytes = '0;
  logic [31:0] m_params = '0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_phase <= P_IDLE; m_active <= '0; m_busy <= 1'b0; m_rsp_valid <= 1'b0;
      m_status <= '0; m_type <= '0; m_count <= '0; m_bytes <= '0; m_params <= '0;
    end else begin
      cyc <= cyc + 1;
      case (m_phase)
        P_IDLE: if (cmd_valid) begin
          m_params <= cmd_params;
          m_type   <= cmd_type;
          m_busy   <= 1'b1;
          if (cmd_opcode > 3'd4) begin
            m_status <= 2'd2; m_count <= '0; m_bytes <= '0;
            m_rsp_valid <= 1'b1; m_phase <= P_RSP;
          end else begin
            m_bit <= cmd_opcode; m_phase <= P_START;
          end
        end
        P_START: begin
          m_active   <= 5'(5'd1 << m_bit);
          m_deadline <= cyc + TO;
          m_phase    <= P_WAIT;
        end
        P_WAIT: begin
          if (substate_complete[m_bit]) begin
            m_bytes  <= ResponseBytes;
            m_count  <= (ResponseByteCount > 4'd4) ? 4'd4 : ResponseByteCount;
            m_status <= 2'd0;
            m_active <= '0; m_deadline <= cyc + TO; m_phase <= P_REL;
          end else if (cyc == m_deadline) begin
            m_bytes <= '0; m_count <= '0; m_status <= 2'd1;
            m_active <= '0; m_deadline <= cyc + TO; m_phase <= P_REL;
          end
        end
        P_REL: begin
          if (!substate_complete[m_bit]) begin
            m_rsp_valid <= 1'b1; m_phase <= P_RSP;
          end else if (cyc == m_deadline) begin
            m_bytes <= '0; m_count <= '0; m_status <= 2'd1;
            m_rsp_valid <= 1'b1; m_phase <= P_RSP;
          end
        end
        default: if (rsp_ready) begin
          m_rsp_valid <= 1'b0; m_busy <= 1'b0; m_phase <= P_IDLE;
        end
      endcase
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      check("active", 32'(substate_active), 32'(m_active));
      check("active_onehot0", 32'($onehot0(substate_active)), 32'd1);
      check("busy", 32'(busy), 32'(m_busy));
      check("cmd_ready", 32'(cmd_ready), 32'(m_phase == P_IDLE));
      check("rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
      check("params", 32'(command_param_data), m_params);
      check("cmd_type", 32'(CommandType), 32'(m_type));
      if (m_rsp_valid) begin
        check("rsp_status", 32'(rsp_status), 32'(m_status));
        check("rsp_count", 32'(rsp_count), 32'(m_count));
        check("rsp_bytes", rsp_bytes, m_bytes);
      end
      if (substate_active != '0) begin
        act_cycles++;
        act_seen = act_seen | substate_active;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic send(input logic [2:0] op, input logic [1:0] ty, input logic [31:0] prm);
    int n = 0;
    while (!cmd_ready && n < 300) begin step(); n++; end
    check("send_ready_wait", 32'(n < 300), 32'd1);
    cmd_valid = 1'b1; cmd_opcode = op; cmd_type = ty; cmd_params = prm;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic take_rsp();
    int n = 0;
    while (!rsp_valid && n < 200) begin step(); n++; end
    check("take_rsp_wait", 32'(n < 200), 32'd1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  // Plays the part of a substate machine for one command, then consumes the response
  task automatic run_cmd(input logic [2:0] op, input logic [1:0] ty, input logic [31:0] prm,
                         input int cdelay, input int rdelay, input int rdy_delay,
                         input logic [31:0] rb, input logic [3:0] rc, input logic [4:0] spur,
                         input bit nxt, input logic [31:0] nxt_prm,
                         output logic [1:0] o_status, output logic [3:0] o_count,
                         output logic [31:0] o_bytes, output int o_wait);
    logic [4:0] oh;
    int n;
    act_cycles = 0;
    act_seen   = '0;
    oh = (op <= 3'd4) ? 5'(5'd1 << op) : 5'd0;
    ResponseBytes = rb;
    ResponseByteCount = rc;
    send(op, ty, prm);
    if (oh != '0) begin
      n = 0;
      while (substate_active == '0 && n < 10) begin step(); n++; end
      check("active_rise_wait", 32'(n < 10), 32'd1);
      substate_complete = spur & ~oh;
      for (int i = 0; i < cdelay; i++) begin
        if (substate_active == '0) break;
        step();
      end
      if (substate_active != '0) substate_complete = (spur & ~oh) | oh;
      n = 0;
      while (substate_active != '0 && n < 100) begin step(); n++; end
      check("active_fall_wait", 32'(n < 100), 32'd1);
      repeat (rdelay) step();
      substate_complete = '0;
    end
    n = 0;
    while (!rsp_valid && n < 200) begin step(); n++; end
    check("rsp_valid_wait", 32'(n < 200), 32'd1);
    o_wait = n; o_status = rsp_status; o_count = rsp_count; o_bytes = rsp_bytes;
    if (nxt) begin
      cmd_valid = 1'b1; cmd_opcode = 3'd7; cmd_type = 2'd3; cmd_params = nxt_prm;
    end
    for (int i = 0; i < rdy_delay; i++) begin
      step();
      if (nxt) begin
        check("hold_params", 32'(command_param_data), prm);
        check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      end
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [1:0]  st;
    logic [3:0]  cnt;
    logic [31:0] by;
    int          wt;
    logic [2:0]  rop;

    reset = 1'b0; cmd_valid = 1'b0; cmd_opcode = '0; cmd_type = '0; cmd_params = '0;
    substate_complete = '0; ResponseBytes = '0; ResponseByteCount = '0; rsp_ready = 1'b0;
    repeat (3) step();
    check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_active", 32'(substate_active), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_params", 32'(command_param_data), 32'd0);
    reset = 1'b1;
    step();

    // READ4 completing after 10 cycles
    run_cmd(3'd1, 2'd2, 32'h01020304, 10, 1, 2, 32'h3CC35AA5, 4'd4, 5'd0, 1'b0, 32'd0,
            st, cnt, by, wt);
    check("t1_status", 32'(st), 32'd0);
    check("t1_count", 32'(cnt), 32'd4);
    check("t1_bytes", by, 32'h3CC35AA5);
    check("t1_active_bit", 32'(act_seen), 32'h02);
    check("t1_params", 32'(command_param_data), 32'h01020304);

    // ADC1 that never completes
    run_cmd(3'd3, 2'd1, 32'hA0B0C0D0, 1000, 0, 1, 32'h12345678, 4'd3, 5'd0, 1'b0, 32'd0,
            st, cnt, by, wt);
    check("t2_status", 32'(st), 32'd1);
    check("t2_count", 32'(cnt), 32'd0);
    check("t2_active_cycles", 32'(act_cycles), 32'(TO));

    // Illegal opcode
    run_cmd(3'd6, 2'd0, 32'h55AA55AA, 0, 0, 0, 32'd0, 4'd0, 5'd0, 1'b0, 32'd0,
            st, cnt, by, wt);
    check("t3_status", 32'(st), 32'd2);
    check("t3_count", 32'(cnt), 32'd0);
    check("t3_latency", 32'(wt <= 1), 32'd1);
    check("t3_no_active", 32'(act_seen), 32'd0);
    check("t3_busy_after", 32'(busy), 32'd0);

    // Response back-pressure with a second command waiting
    run_cmd(3'd2, 2'd1, 32'h0BADF00D, 3, 2, 100, 32'hCAFEBABE, 4'd2, 5'd0, 1'b1, 32'h77665544,
            st, cnt, by, wt);
    check("t4_status", 32'(st), 32'd0);
    check("t4_count", 32'(cnt), 32'd2);
    step();
    cmd_valid = 1'b0;
    check("t4_second_params", 32'(command_param_data), 32'h77665544);
    take_rsp();

    // TEST with a spurious ADC4 completion during the wait
    run_cmd(3'd4, 2'd3, 32'hFEEDFACE, 8, 1, 1, 32'h0000BEEF, 4'd2, 5'b00100, 1'b0, 32'd0,
            st, cnt, by, wt);
    check("t5_status", 32'(st), 32'd0);
    check("t5_bytes", by, 32'h0000BEEF);
    check("t5_active_bit", 32'(act_seen), 32'h10);

    // Reset asserted while WRITE4 is waiting for completion
    send(3'd0, 2'd1, 32'hDEADBEEF);
    repeat (5) step();
    check("t6_active_before", 32'(substate_active), 32'h01);
    reset = 1'b0;
    #1;
    check("t6_active_drop", 32'(substate_active), 32'd0);
    check("t6_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t6_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (3) step();
    reset = 1'b1;
    step();
    check("t6_ready_after", 32'(cmd_ready), 32'd1);
    check("t6_busy_after", 32'(busy), 32'd0);
    run_cmd(3'd0, 2'd0, 32'h10203040, 3, 0, 0, 32'h11223344, 4'd9, 5'd0, 1'b0, 32'd0,
            st, cnt, by, wt);
    check("t6_status", 32'(st), 32'd0);
    check("t6_count_clamp", 32'(cnt), 32'd4);
    check("t6_bytes", by, 32'h11223344);

    // Randomized traffic: legal/illegal opcodes, completions racing the timeout, spurious bits
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 9) < 8) rop = 3'($urandom_range(0, 4));
      else rop = 3'($urandom_range(5, 7));
      run_cmd(rop, 2'($urandom_range(0, 3)), $urandom(), int'($urandom_range(0, 70)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), $urandom(),
              4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)), 1'b0, 32'd0,
              st, cnt, by, wt);
    end

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
